// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit in the EX stage of the 5-stage pipeline.
// MULT/MULTU hold busy for MULT_CYCLES cycles and DIV/DIVU for DIV_CYCLES; HI/LO commit as busy falls. MTHI/MTLO write at the next edge.
// There is no input handshake: start is ignored while busy, and the hazard unit stalls on busy.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;

    // The result is derived combinationally from the latched operands.
    // Only the commit edge is timed.
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_nz, b_u_nz;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic        start_md, last_cycle;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division works on magnitudes. The magnitude of 0x80000000 is still 0x80000000 as an
    // unsigned value, so 0x80000000 / -1 returns 0x80000000 with no overflow path.
    assign a_mag    = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;
    // A divide by zero never commits. The divisor is clamped only to keep the divider output defined.
    assign b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign b_u_nz   = (b_q == 32'd0) ? 32'd1 : b_q;
    assign quo_mag  = a_mag / b_mag_nz;
    assign rem_mag  = a_mag % b_mag_nz;
    assign quo_s    = (a_q[31] ^ b_q[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_s    = a_q[31] ? (~rem_mag + 32'd1) : rem_mag;
    assign quo_u    = a_q / b_u_nz;
    assign rem_u    = a_q % b_u_nz;

    assign start_md   = start && (op[2] == 1'b0);
    assign last_cycle = (cnt_q == CW'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: leave IDLE on a multiply/divide start, and return to IDLE on the final counted cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_md)   state_d = S_BUSY;
            S_BUSY: if (last_cycle) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Output logic: busy is decoded straight from the state flop, with no path from start
    always_comb begin
        busy = (state_q == S_BUSY);
    end

    // Datapath next state: operand latch, cycle counter, MTHI/MTLO writes and result commit
    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                case (op)
                    3'b000, 3'b001, 3'b010, 3'b011: begin
                        a_d   = A;
                        b_d   = B;
                        op_d  = op[1:0];
                        cnt_d = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end
                    3'b100:  hi_d = A;
                    3'b101:  lo_d = A;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (last_cycle) begin
                case (op_q)
                    2'b00: {hi_d, lo_d} = prod_s;
                    2'b01: {hi_d, lo_d} = prod_u;
                    2'b10: if (b_q != 32'd0) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                    default: if (b_q != 32'd0) begin
                        hi_d = rem_u;
                        lo_d = quo_u;
                    end
                endcase
            end
        end
    end

    // Datapath registers; reset clears everything, which aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit.
// One DUT uses the default latencies and a second uses MULT_CYCLES=1.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [2:0]  op, op2;
    logic [31:0] A, B, A2, B2;
    logic        busy, busy2;
    logic [31:0] HI, LO, HI2, LO2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO)
    );

    mult_div_unit #(.MULT_CYCLES(1), .DIV_CYCLES(10)) dut_fast (
        .clk(clk), .reset(reset), .start(start2), .op(op2), .A(A2), .B(B2),
        .busy(busy2), .HI(HI2), .LO(LO2)
    );

    // Drive a one-cycle start pulse. The task returns on the negedge of busy cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
    endtask

    // Count the remaining busy cycles. The loop bound limits the wait if busy sticks high.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 3'b111; A = '0; B = '0;
        start2 = 1'b0; op2 = 3'b111; A2 = '0; B2 = '0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_mult;
        issue(3'b000, 32'hFFFFFFFE, 32'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_start: got %b expected 1", busy); end
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_async: got %b expected 0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL midrst_hi: got %h expected 00000000", HI); end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_later: got %b expected 0", busy); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL midrst_lo_later: got %h expected 00000000", LO); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL midrst_hi_later: got %h expected 00000000", HI); end
    endtask

    task automatic test_mult;
        int n;
        issue(3'b000, 32'hFFFFFFFE, 32'd3);
        count_busy(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", LO); end
        issue(3'b001, 32'hFFFFFFFE, 32'd3);
        count_busy(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy_len: got %0d expected 5", n); end
        checks++; if (HI !== 32'h00000002) begin errors++; $display("FAIL multu_hi: got %h expected 00000002", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo: got %h expected fffffffa", LO); end
    endtask

    task automatic test_div;
        int n;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_len: got %0d expected 10", n); end
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", HI); end
        issue(3'b011, 32'd7, 32'd2);
        count_busy(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divu_busy_len: got %0d expected 10", n); end
        checks++; if (LO !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 00000003", LO); end
        checks++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 00000001", HI); end
    endtask

    task automatic test_div_boundary;
        int n;
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n);
        checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", LO); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected 00000000", HI); end
        issue(3'b100, 32'h1234, 32'd0);
        issue(3'b101, 32'h1234, 32'd0);
        issue(3'b011, 32'd5, 32'd0);
        count_busy(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divz_busy_len: got %0d expected 10", n); end
        checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL divz_hi: got %h expected 00001234", HI); end
        checks++; if (LO !== 32'h1234) begin errors++; $display("FAIL divz_lo: got %h expected 00001234", LO); end
    endtask

    task automatic test_mthi_mtlo;
        issue(3'b100, 32'hDEADBEEF, 32'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_hi: got %h expected deadbeef", HI); end
        checks++; if (LO !== 32'h1234) begin errors++; $display("FAIL mthi_lo_kept: got %h expected 00001234", LO); end
        issue(3'b101, 32'hCAFEF00D, 32'd0);
        checks++; if (LO !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_lo: got %h expected cafef00d", LO); end
        issue(3'b110, 32'h11111111, 32'd1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'hDEADBEEF) begin errors++; $display("FAIL noop_hi: got %h expected deadbeef", HI); end
        checks++; if (LO !== 32'hCAFEF00D) begin errors++; $display("FAIL noop_lo: got %h expected cafef00d", LO); end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(3'b000, 32'd5, 32'd6);
        @(negedge clk);
        start = 1'b1; op = 3'b001; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
        count_busy(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_busy_rest: got %0d expected 3", n); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL b2b_hi: got %h expected 00000000", HI); end
        checks++; if (LO !== 32'd30) begin errors++; $display("FAIL b2b_lo: got %h expected 0000001e", LO); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_restart: got %b expected 0", busy); end
    endtask

    task automatic test_mult_fast;
        @(negedge clk);
        start2 = 1'b1; op2 = 3'b000; A2 = 32'hFFFFFFFE; B2 = 32'd3;
        @(negedge clk);
        start2 = 1'b0; op2 = 3'b111;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL fast_busy_on: got %b expected 1", busy2); end
        @(negedge clk);
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL fast_busy_off: got %b expected 0", busy2); end
        checks++; if (HI2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL fast_hi: got %h expected ffffffff", HI2); end
        checks++; if (LO2 !== 32'hFFFFFFFA) begin errors++; $display("FAIL fast_lo: got %h expected fffffffa", LO2); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_mult();
        test_mult();
        test_div();
        test_div_boundary();
        test_mthi_mtlo();
        test_back_to_back();
        test_mult_fast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
